sss_div_seq: RTL and testbench
==============================

Name: sss_div_seq

Overview:
- Sequential signed shift-and-subtract (restoring) divider, one quotient bit per clock.
- Inverse companion to the shift-and-accumulate multiplier in the Multipliers/ShiftAndAcc area: for any product P = A*B that fits in WIDTH bits, dividing P by B returns A with remainder 0.
- Start/busy/done handshake lets a controller or bench drive it directly.

Parameters:
- WIDTH, 32, operand, quotient and remainder width (two's complement).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- A  input  WIDTH  signed dividend; captured on accepted start
- B  input  WIDTH  signed divisor; captured on accepted start
- busy  output  1  high from the cycle after accept until done (inclusive)
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; sign follows dividend, |rem| < |B|
- div_by_zero  output  1  set with done when B was 0; held with results

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and registers cleared. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, SIGN.
- IDLE, start=1, B!=0:
  - latch |A|, |B|, sign_q = A[msb]^B[msb], sign_r = A[msb].
  - rem = 0 (WIDTH+1 bits), cnt = WIDTH; next state CALC.
- IDLE, start=1, B=0:
  - latch A; next state SIGN with dbz flag.
- CALC, each cycle:
  - rem = {rem, dvd[msb]}; dvd shifts left by 1.
  - If rem >= |B|: rem -= |B| and shift 1 into dvd lsb; else shift 0.
  - cnt decrements; when cnt reaches 1 on this cycle, next state SIGN.
- SIGN:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem; done=1; next state IDLE.
  - With dbz: quotient = all ones, remainder = A, div_by_zero=1.
- Latency: start sampled at edge N (normal) -> done high in the cycle after edge N+WIDTH+1. With B=0: done after edge N+1.
- busy=1 in CALC and SIGN, 0 in IDLE. start while busy is ignored; no queuing.
- Back-to-back: start may be asserted in the done cycle, but it is not accepted because state is SIGN. It is accepted in the following IDLE cycle.
- Outputs quotient/remainder/div_by_zero hold their last values until the next SIGN cycle. div_by_zero is cleared at the next accepted start.
- Magnitudes use WIDTH-bit unsigned arithmetic, so |MIN| = 2^(WIDTH-1) is handled exactly.
- MIN / -1 wraps: quotient = MIN, remainder = 0. No overflow flag.
- A=0: quotient 0, remainder 0, full normal latency. No early termination.

Decomposition:
- Shared package/header sam_pkg: state encodings (S_IDLE, S_CALC, S_SIGN) and default WIDTH.
- One natural sub-module: div_step (combinational). Takes rem, dvd msb and |B|; returns next rem and quotient bit. It is reused by any future radix-2 non-restoring variant.
- Sign handling and counter stay inline.

Test Plan:
- A=2000, B=-40, start 1 cycle -> after 33 further edges: done=1, quotient=-50 (FFFFFFCE), remainder=0, div_by_zero=0; busy high exactly 33 cycles.
- Sign matrix:
  - 7/-2 -> q=-3, r=1
  - -7/2 -> q=-3, r=-1
  - -7/-2 -> q=3, r=-1
  - 998001/999 -> q=999, r=0
- Divide by zero: A=98765, B=0 -> done 2 cycles after start, quotient=FFFFFFFF, remainder=98765, div_by_zero=1. Next division 6300/70 -> q=90, r=0, div_by_zero=0.
- Boundaries:
  - 80000000/FFFFFFFF -> q=80000000, r=0
  - 80000000/1 -> q=80000000, r=0
  - 0/5 -> q=0, r=0
- Handshake: start re-pulsed mid-CALC with A=1, B=1 -> ignored, first result (-1000000/2000 -> q=-500) intact; start held high through done -> second op accepted in the cycle after done.
- Reset asserted asynchronously (between edges) mid-CALC of -3250/325 -> outputs zero immediately, no done. Then 5200/-65 -> q=-80, r=0 with nominal latency.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared definitions for the sequential shift-and-subtract divider.
//   DEF_WIDTH : default operand / quotient / remainder width
//   state_t   : divider control states
package sam_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/sss_div_seq_div_step.sv
// One radix-2 restoring division step (combinational).
//   rem      : partial remainder, always < divisor on entry
//   dvd_msb  : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude (unsigned)
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit: rem < divisor <= 2^(WIDTH-1)
  // guarantees the shifted value fits in WIDTH+1 bits.
  assign rem_shift = {rem, dvd_msb};
  assign q_bit     = (rem_shift >= {1'b0, divisor});
  // When the subtraction is taken the true result is < divisor, so the
  // modulo-2^WIDTH difference is exact.
  assign diff      = rem_shift[WIDTH-1:0] - divisor;
  assign rem_next  = q_bit ? diff : rem_shift[WIDTH-1:0];

endmodule

// File: rtl/sss_div_seq.sv
// Sequential signed restoring divider, one quotient bit per clock.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request a division (sampled only when idle)
//   A, B         : signed dividend / divisor, captured on accept
//   busy         : operation in flight, through the done cycle
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : signed quotient, truncated toward zero
//   remainder    : signed remainder, sign of dividend
//   div_by_zero  : set with done when B was zero, held with results
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | WIDTH shift/subtract iterations on magnitudes
// S_SIGN | apply result signs (or divide-by-zero values)
module sss_div_seq
  import sam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dbz;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  // Unsigned WIDTH-bit magnitudes: the most negative value maps to
  // 2^(WIDTH-1) exactly.
  assign a_mag  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag  = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  assign b_zero = (B == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (mag_b),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = b_zero ? S_SIGN : S_CALC;
      S_CALC:  if (cnt == CW'(1)) state_nx = S_SIGN;
      S_SIGN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered handshake. done is registered out of S_SIGN so
  // results and the pulse appear together; busy lags the state by one cycle
  // so it spans from the cycle after accept through the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      mag_b       <= '0;
      rem         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state != S_IDLE);
      done <= (state == S_SIGN);
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            rem         <= '0;
            if (b_zero) begin
              // Raw dividend is kept in dvd so it can be returned as remainder.
              dvd    <= A;
              mag_b  <= '0;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
              dbz    <= 1'b1;
              cnt    <= '0;
            end else begin
              dvd    <= a_mag;
              mag_b  <= b_mag;
              sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r <= A[WIDTH-1];
              dbz    <= 1'b0;
              cnt    <= CW'(WIDTH);
            end
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt - CW'(1);
        end
        S_SIGN: begin
          if (dbz) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= sign_q ? (~dvd + WIDTH'(1)) : dvd;
            remainder <= sign_r ? (~rem + WIDTH'(1)) : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sss_div_seq.sv
module tb_sss_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  sss_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: arithmetic division on 64-bit integers, timing from
  // the handshake rules (accept when idle, done WIDTH+1 edges later, or 1 edge
  // later for a zero divisor; the next accept is possible after the done edge).
  int          ecnt = 0;
  int          m_acc = 0;
  int          m_due = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  bit          m_busy = 0;
  bit          m_dbz = 0;
  bit          p_dbz = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_busy = 0; m_dbz = 0;
      m_q = '0; m_r = '0;
    end else begin
      longint la, lb;
      ecnt++;
      m_done = m_active && (ecnt == m_due);
      if (m_done) begin
        m_q = p_q; m_r = p_r; m_dbz = p_dbz;
      end
      m_busy = m_active && (ecnt >= m_acc + 1) && (ecnt <= m_due);
      if (start && (!m_active || ecnt > m_due)) begin
        m_active = 1;
        m_acc    = ecnt;
        m_dbz    = 0;
        la = longint'($signed(A));
        lb = longint'($signed(B));
        if (lb == 0) begin
          m_due = ecnt + 1;
          p_q = '1; p_r = A; p_dbz = 1;
        end else begin
          m_due = ecnt + W + 1;
          p_q = 32'(la / lb); p_r = 32'(la % lb); p_dbz = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_busy", {31'b0, busy}, {31'b0, m_busy});
    chk("mdl_done", {31'b0, done}, {31'b0, m_done});
    chk("mdl_quotient", quotient, m_q);
    chk("mdl_remainder", remainder, m_r);
    chk("mdl_dbz", {31'b0, div_by_zero}, {31'b0, m_dbz});
  end

  // Counts rising edges until done is seen at a falling edge (bounded).
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (busy) bc++;
      if (done) break;
    end
  endtask

  task automatic do_div(input string nm, input int a, input int b, input int eq, input int er,
                        input logic edbz, input int elat);
    int lat, bc;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, bc, elat);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
  endtask

  initial begin
    int lat, bc;
    bit seen;
    #22 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    do_div("d2000_m40", 2000, -40, 32'hFFFFFFCE, 0, 1'b0, 33);
    do_div("d7_m2", 7, -2, -3, 1, 1'b0, 33);
    do_div("dm7_2", -7, 2, -3, -1, 1'b0, 33);
    do_div("dm7_m2", -7, -2, 3, -1, 1'b0, 33);
    do_div("d998001_999", 998001, 999, 999, 0, 1'b0, 33);
    do_div("dbz", 98765, 0, 32'hFFFFFFFF, 98765, 1'b1, 1);
    do_div("d6300_70", 6300, 70, 90, 0, 1'b0, 33);
    do_div("min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0, 33);
    do_div("min_1", 32'h80000000, 1, 32'h80000000, 0, 1'b0, 33);
    do_div("zero_5", 0, 5, 0, 0, 1'b0, 33);

    // Start re-pulsed during CALC must be ignored.
    @(posedge clk); #1;
    A = -1000000; B = 2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 A = 1; B = 1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bc);
    chk("glitch_done", {31'b0, done}, 32'd1);
    chk("glitch_q", quotient, -500);
    chk("glitch_r", remainder, 0);

    // Start held high through done: second op accepted on the edge after done.
    @(posedge clk); #1;
    A = 121; B = 11; start = 1'b1;
    @(posedge clk); #1;
    A = -45; B = 7;
    wait_done(lat, bc);
    chk("held1_lat", lat, 33);
    chk("held1_q", quotient, 11);
    wait_done(lat, bc);
    start = 1'b0;
    chk("held2_done", {31'b0, done}, 32'd1);
    chk("held2_lat", lat, 34);
    chk("held2_q", quotient, -6);
    chk("held2_r", remainder, -3);

    // Asynchronous reset in the middle of a calculation.
    @(posedge clk); #1;
    A = -3250; B = 325; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("arst_no_done", {31'b0, seen}, 32'd0);
    do_div("d5200_m65", 5200, -65, -80, 0, 1'b0, 33);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
